// File: rtl/safe_lock_fsm_if.sv
// Keypad-to-lock-controller bundle: encoder key inputs plus lock status outputs.
interface safe_lock_fsm_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       unlocked;
  logic       locked_out;
  logic       error;
  logic       code_saved;
  logic [3:0] digit_count;
  logic [3:0] fail_count;

  // Keypad side: drives the encoder outputs and observes the lock status.
  modport master (
    output key_code, key_valid,
    input  unlocked, locked_out, error, code_saved, digit_count, fail_count
  );

  // Lock controller side.
  modport slave (
    input  key_code, key_valid,
    output unlocked, locked_out, error, code_saved, digit_count, fail_count
  );
endinterface

// File: rtl/safe_lock_fsm.sv
// Safe lock sequencing controller: turns keypad presses into single events,
// collects a BCD entry, checks it against the stored code and handles the
// open window, code change and lockout after repeated failures.
module safe_lock_fsm #(
  parameter int                    CODE_LEN       = 4,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    UNLOCK_CYCLES  = 500,
  parameter int                    LOCKOUT_CYCLES = 1000,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234
) (
  input logic           clk,
  input logic           rst_n,
  safe_lock_fsm_if.slave bus
);

  localparam int ENTRY_W = 4 * CODE_LEN;
  localparam int T_MAX   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  localparam logic [3:0]         CODE_LEN_C  = 4'(CODE_LEN);
  localparam logic [3:0]         MAX_TRIES_C = 4'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] UNLOCK_T    = TIMER_W'(UNLOCK_CYCLES);
  localparam logic [TIMER_W-1:0] LOCKOUT_T   = TIMER_W'(LOCKOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_OPEN,
    ST_LOCKOUT
  } state_t;

  state_t             state_q, state_d;
  logic [ENTRY_W-1:0] stored_q, stored_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [3:0]         digit_count_q, digit_count_d;
  logic [3:0]         fail_count_q, fail_count_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               key_valid_q;
  logic               unlocked_q, unlocked_d;
  logic               locked_out_q, locked_out_d;
  logic               error_q, error_d;
  logic               code_saved_q, code_saved_d;

  logic key_event;
  logic is_digit;
  logic is_clear;
  logic timer_running;
  logic expiring;
  logic accept;
  logic entry_full;
  logic entry_match;

  // A key press is the rising edge of the encoder valid level; a held key
  // therefore yields one event. Codes above ENTER are never accepted, and a
  // press landing on the cycle the timer runs out loses to the timeout.
  assign key_event     = bus.key_valid & ~key_valid_q;
  assign is_digit      = (bus.key_code <= 4'd9);
  assign is_clear      = (bus.key_code == 4'd10);
  assign timer_running = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);
  assign expiring      = timer_running && (timer_q <= TIMER_ONE);
  assign accept        = key_event && (bus.key_code <= 4'd11) &&
                         ((state_q == ST_LOCKED) || ((state_q == ST_OPEN) && !expiring));
  assign entry_full    = (digit_count_q >= CODE_LEN_C);
  assign entry_match   = entry_full && (entry_q == stored_q);

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d       = state_q;
    stored_d      = stored_q;
    entry_d       = entry_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    timer_d       = timer_q;
    error_d       = 1'b0;
    code_saved_d  = 1'b0;

    if (timer_running) begin
      timer_d = expiring ? '0 : (timer_q - TIMER_ONE);
    end

    if (expiring) begin
      state_d = ST_LOCKED;
      if (state_q == ST_OPEN) begin
        entry_d       = '0;
        digit_count_d = 4'd0;
      end else begin
        fail_count_d  = 4'd0;
      end
    end

    if (accept) begin
      if (state_q == ST_OPEN) begin
        timer_d = UNLOCK_T;
      end
      if (is_digit) begin
        if (!entry_full) begin
          entry_d       = ENTRY_W'({entry_q, bus.key_code});
          digit_count_d = digit_count_q + 4'd1;
        end
      end else if (is_clear) begin
        entry_d       = '0;
        digit_count_d = 4'd0;
      end else if (state_q == ST_LOCKED) begin
        entry_d       = '0;
        digit_count_d = 4'd0;
        if (entry_match) begin
          state_d      = ST_OPEN;
          fail_count_d = 4'd0;
          timer_d      = UNLOCK_T;
        end else begin
          error_d      = 1'b1;
          fail_count_d = fail_count_q + 4'd1;
          if ((fail_count_q + 4'd1) == MAX_TRIES_C) begin
            state_d = ST_LOCKOUT;
            timer_d = LOCKOUT_T;
          end
        end
      end else begin
        if (entry_full) begin
          stored_d      = entry_q;
          code_saved_d  = 1'b1;
          entry_d       = '0;
          digit_count_d = 4'd0;
        end else begin
          error_d = 1'b1;
        end
      end
    end

    unlocked_d   = (state_d == ST_OPEN);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  // Single state register for the FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOCKED;
      stored_q      <= DEFAULT_CODE;
      entry_q       <= '0;
      digit_count_q <= 4'd0;
      fail_count_q  <= 4'd0;
      timer_q       <= '0;
      key_valid_q   <= 1'b0;
      unlocked_q    <= 1'b0;
      locked_out_q  <= 1'b0;
      error_q       <= 1'b0;
      code_saved_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      stored_q      <= stored_d;
      entry_q       <= entry_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      timer_q       <= timer_d;
      key_valid_q   <= bus.key_valid;
      unlocked_q    <= unlocked_d;
      locked_out_q  <= locked_out_d;
      error_q       <= error_d;
      code_saved_q  <= code_saved_d;
    end
  end

  assign bus.unlocked    = unlocked_q;
  assign bus.locked_out  = locked_out_q;
  assign bus.error       = error_q;
  assign bus.code_saved  = code_saved_q;
  assign bus.digit_count = digit_count_q;
  assign bus.fail_count  = fail_count_q;

endmodule
